// File: rtl/hilo_md_unit_pkg.sv
// Shared op codes and divider FSM encodings for the HI/LO multiply/divide unit.
package hilo_md_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_MULT  = 4'h1;
    localparam logic [3:0] OP_MULTU = 4'h2;
    localparam logic [3:0] OP_DIV   = 4'h3;
    localparam logic [3:0] OP_DIVU  = 4'h4;
    localparam logic [3:0] OP_MTHI  = 4'h5;
    localparam logic [3:0] OP_MTLO  = 4'h6;
    localparam logic [3:0] OP_MADD  = 4'h7;
    localparam logic [3:0] OP_MADDU = 4'h8;
    localparam logic [3:0] OP_MSUB  = 4'h9;
    localparam logic [3:0] OP_MSUBU = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    // Signed variants sign-extend operands; everything else is treated as unsigned.
    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/hilo_md_unit_if.sv
// Issue/result bundle between the EX stage (master) and the HI/LO unit (slave).
interface hilo_md_unit_if #(parameter int DATA_W = 32);

    logic              valid;
    logic [3:0]        op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              cancel;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;

    modport master (
        output valid, op, src_a, src_b, cancel,
        input  busy, done, hi_out, lo_out
    );

    modport slave (
        input  valid, op, src_a, src_b, cancel,
        output busy, done, hi_out, lo_out
    );

endinterface

// File: rtl/hilo_md_unit_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes: one quotient bit per step.
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic              step_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quot_o,
    output logic [DATA_W-1:0] rem_o,
    output logic              last_o
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   diff;

    // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
    assign rem_shift = {rem_q, quot_q[DATA_W-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};
    assign last_o    = step_i && (cnt_q == CW'(DATA_W - 1));
    assign quot_o    = quot_q;
    assign rem_o     = rem_q;

    always_comb begin
        rem_d  = rem_q;
        quot_d = quot_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            rem_d  = '0;
            quot_d = dividend_i;
            dvs_d  = divisor_i;
            cnt_d  = '0;
        end else if (abort_i) begin
            cnt_d = '0;
        end else if (step_i) begin
            if (!diff[DATA_W]) begin
                rem_d  = diff[DATA_W-1:0];
                quot_d = {quot_q[DATA_W-2:0], 1'b1};
            end else begin
                rem_d  = rem_shift[DATA_W-1:0];
                quot_d = {quot_q[DATA_W-2:0], 1'b0};
            end
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/hilo_md_unit.sv
// HI/LO registers with single-cycle multiply/accumulate and a multi-cycle signed/unsigned divider.
module hilo_md_unit
    import hilo_md_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter bit MACC_EN = 1'b1
) (
    input  logic           clk,
    input  logic           resetn,
    hilo_md_unit_if.slave  bus
);

    localparam int PW = 2 * DATA_W;

    div_state_e        state_q, state_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d;

    logic              accept, is_signed;
    logic              div_start, div_step, div_abort, div_last;
    logic [DATA_W-1:0] mag_a, mag_b, quot, rem;
    logic [PW-1:0]     ext_a, ext_b, prod, acc;

    assign accept    = bus.valid && !bus.cancel && (state_q == ST_IDLE);
    assign is_signed = op_is_signed(bus.op);

    // Extending to the full product width lets one truncated multiply serve both signednesses.
    assign ext_a = is_signed ? {{DATA_W{bus.src_a[DATA_W-1]}}, bus.src_a} : {{DATA_W{1'b0}}, bus.src_a};
    assign ext_b = is_signed ? {{DATA_W{bus.src_b[DATA_W-1]}}, bus.src_b} : {{DATA_W{1'b0}}, bus.src_b};
    assign prod  = ext_a * ext_b;
    assign acc   = {hi_q, lo_q};

    assign mag_a = (is_signed && bus.src_a[DATA_W-1]) ? -bus.src_a : bus.src_a;
    assign mag_b = (is_signed && bus.src_b[DATA_W-1]) ? -bus.src_b : bus.src_b;

    div_iter #(.DATA_W(DATA_W)) u_div (
        .clk        (clk),
        .resetn     (resetn),
        .start_i    (div_start),
        .step_i     (div_step),
        .abort_i    (div_abort),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .quot_o     (quot),
        .rem_o      (rem),
        .last_o     (div_last)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        div_start = 1'b0;
        div_step  = 1'b0;
        div_abort = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            {hi_d, lo_d} = prod;
                            done_d       = 1'b1;
                        end
                        OP_MTHI: begin
                            hi_d   = bus.src_a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.src_a;
                            done_d = 1'b1;
                        end
                        OP_MADD, OP_MADDU: begin
                            if (MACC_EN) begin
                                {hi_d, lo_d} = acc + prod;
                                done_d       = 1'b1;
                            end
                        end
                        OP_MSUB, OP_MSUBU: begin
                            if (MACC_EN) begin
                                {hi_d, lo_d} = acc - prod;
                                done_d       = 1'b1;
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d   = ST_DIV;
                            div_start = 1'b1;
                            // A zero divisor keeps the raw all-ones quotient regardless of signs.
                            qneg_d    = is_signed && (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1])
                                        && (|bus.src_b);
                            rneg_d    = is_signed && bus.src_a[DATA_W-1];
                        end
                        default: ;
                    endcase
                end
            end
            ST_DIV: begin
                if (bus.cancel) begin
                    state_d   = ST_IDLE;
                    div_abort = 1'b1;
                end else begin
                    div_step = 1'b1;
                    if (div_last) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (bus.cancel) begin
                    div_abort = 1'b1;
                end else begin
                    lo_d   = qneg_q ? -quot : quot;
                    hi_d   = rneg_q ? -rem : rem;
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;

`ifdef HILO_MD_ASSERT_ON
    // Issuing while busy is a pipeline bug: the op is silently dropped.
    a_no_issue_while_busy: assert property (@(posedge clk) disable iff (!resetn)
        !(bus.valid && bus.busy))
        else $error("hilo_md_unit: op issued while busy");
`endif

endmodule

// File: tb/tb_hilo_md_unit.sv
// Directed bench: vector table for single-cycle ops, hand sequences for divide/cancel/reset/builds.
module tb_hilo_md_unit;
    import hilo_md_pkg::*;

    logic clk;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    hilo_md_unit_if #(.DATA_W(32)) bus ();
    hilo_md_unit_if #(.DATA_W(32)) bus_nm ();
    hilo_md_unit_if #(.DATA_W(8))  bus_w8 ();

    hilo_md_unit #(.DATA_W(32), .MACC_EN(1'b1)) dut        (.clk(clk), .resetn(resetn), .bus(bus));
    hilo_md_unit #(.DATA_W(32), .MACC_EN(1'b0)) dut_nomacc (.clk(clk), .resetn(resetn), .bus(bus_nm));
    hilo_md_unit #(.DATA_W(8),  .MACC_EN(1'b1)) dut_w8     (.clk(clk), .resetn(resetn), .bus(bus_w8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cancel;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        done;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one op for one cycle; returns at the negedge of the following cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic cncl);
        @(negedge clk);
        bus.valid = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.cancel = cncl;
        @(negedge clk);
        bus.valid = 1'b0; bus.op = OP_NOP; bus.cancel = 1'b0;
    endtask

    task automatic div_check(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int  n;
        logic early_done;
        issue(op, a, b, 1'b0);
        n = 0;
        early_done = 1'b0;
        while (bus.busy && n < 100) begin
            if (bus.done) early_done = 1'b1;
            n++;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, 32'(n), 32'd33);
        check({name, " done_while_busy"}, 32'(early_done), 32'd0);
        check({name, " done"}, 32'(bus.done), 32'd1);
        check({name, " lo"}, bus.lo_out, exp_lo);
        check({name, " hi"}, bus.hi_out, exp_hi);
        $display("div %s: a=0x%h b=0x%h -> hi=0x%h lo=0x%h busy=%0d", name, a, b, bus.hi_out, bus.lo_out, n);
    endtask

    task automatic div8_check(input string name, input logic [3:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        int n;
        @(negedge clk);
        bus_w8.valid = 1'b1; bus_w8.op = op; bus_w8.src_a = a; bus_w8.src_b = b;
        @(negedge clk);
        bus_w8.valid = 1'b0; bus_w8.op = OP_NOP;
        n = 0;
        while (bus_w8.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, 32'(n), 32'd9);
        check({name, " done"}, 32'(bus_w8.done), 32'd1);
        check({name, " lo"}, 32'(bus_w8.lo_out), 32'(exp_lo));
        check({name, " hi"}, 32'(bus_w8.hi_out), 32'(exp_hi));
        $display("div8 %s: a=0x%h b=0x%h -> hi=0x%h lo=0x%h busy=%0d", name, a, b, bus_w8.hi_out, bus_w8.lo_out, n);
    endtask

    initial begin
        logic [31:0] hold_hi, hold_lo;
        logic        saw_done, changed;

        vecs[0]  = '{OP_MTHI,  32'h12345678, 32'h0,        1'b0, 32'h12345678, 32'h00000000, 1'b1};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h7,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1};
        vecs[2]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h2,        1'b0, 32'h00000001, 32'hFFFFFFFE, 1'b1};
        vecs[3]  = '{OP_MTHI,  32'h0,        32'h0,        1'b0, 32'h00000000, 32'hFFFFFFFE, 1'b1};
        vecs[4]  = '{OP_MTLO,  32'hFFFFFFFF, 32'h0,        1'b0, 32'h00000000, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{OP_MADDU, 32'h1,        32'h1,        1'b0, 32'h00000001, 32'h00000000, 1'b1};
        vecs[6]  = '{OP_MSUB,  32'h1,        32'h2,        1'b0, 32'h00000000, 32'hFFFFFFFE, 1'b1};
        vecs[7]  = '{OP_MADD,  32'hFFFFFFFF, 32'h5,        1'b0, 32'h00000000, 32'hFFFFFFF9, 1'b1};
        vecs[8]  = '{OP_MSUBU, 32'hFFFFFFFF, 32'h2,        1'b0, 32'hFFFFFFFE, 32'hFFFFFFFB, 1'b1};
        vecs[9]  = '{OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b1};
        vecs[10] = '{4'hB,     32'h7,        32'h7,        1'b0, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0};
        vecs[11] = '{OP_NOP,   32'h7,        32'h7,        1'b0, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0};
        vecs[12] = '{OP_MTHI,  32'hDEAD,     32'h0,        1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0};
        vecs[13] = '{OP_MTLO,  32'h0,        32'h0,        1'b0, 32'hFFFFFFFC, 32'h00000000, 1'b1};

        bus.valid = 1'b0;    bus.op = OP_NOP;    bus.src_a = '0;    bus.src_b = '0;    bus.cancel = 1'b0;
        bus_nm.valid = 1'b0; bus_nm.op = OP_NOP; bus_nm.src_a = '0; bus_nm.src_b = '0; bus_nm.cancel = 1'b0;
        bus_w8.valid = 1'b0; bus_w8.op = OP_NOP; bus_w8.src_a = '0; bus_w8.src_b = '0; bus_w8.cancel = 1'b0;

        resetn = 1'b1;
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        check("reset hi", bus.hi_out, 32'h0);
        check("reset lo", bus.lo_out, 32'h0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        $display("reset: hi=0x%h lo=0x%h busy=%b done=%b", bus.hi_out, bus.lo_out, bus.busy, bus.done);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cancel);
            check($sformatf("vec%0d hi", i), bus.hi_out, vecs[i].hi);
            check($sformatf("vec%0d lo", i), bus.lo_out, vecs[i].lo);
            check($sformatf("vec%0d done", i), 32'(bus.done), 32'(vecs[i].done));
            $display("vec%0d: op=%h a=0x%h b=0x%h cancel=%b -> hi=0x%h lo=0x%h done=%b",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cancel, bus.hi_out, bus.lo_out, bus.done);
        end

        div_check("div_m7_2",    OP_DIV,  32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        div_check("divu_100_0",  OP_DIVU, 32'd100,      32'h0,        32'd100,      32'hFFFFFFFF);
        div_check("div_ovf",     OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
        div_check("div_7_m2",    OP_DIV,  32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD);

        // Cancel in DIV cycle 10, with a dropped MTLO issued while busy.
        hold_hi = bus.hi_out;
        hold_lo = bus.lo_out;
        issue(OP_DIVU, 32'd9, 32'd3, 1'b0);
        repeat (4) @(negedge clk);
        bus.valid = 1'b1; bus.op = OP_MTLO; bus.src_a = 32'h5555;
        @(negedge clk);
        bus.valid = 1'b0; bus.op = OP_NOP;
        check("cancel busy_before", 32'(bus.busy), 32'd1);
        repeat (5) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel busy_after", 32'(bus.busy), 32'd0);
        saw_done = 1'b0;
        changed  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) saw_done = 1'b1;
            if (bus.hi_out !== hold_hi || bus.lo_out !== hold_lo) changed = 1'b1;
            @(negedge clk);
        end
        check("cancel no_done", 32'(saw_done), 32'd0);
        check("cancel hilo_changed", 32'(changed), 32'd0);
        $display("cancel div: hi=0x%h lo=0x%h busy=%b", bus.hi_out, bus.lo_out, bus.busy);

        div_check("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'h0, 32'h3);

        // Cancel during FIX beats the result write.
        issue(OP_DIVU, 32'd20, 32'd6, 1'b0);
        repeat (32) @(negedge clk);
        check("fixcancel busy_in_fix", 32'(bus.busy), 32'd1);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("fixcancel busy", 32'(bus.busy), 32'd0);
        check("fixcancel done", 32'(bus.done), 32'd0);
        check("fixcancel hi", bus.hi_out, 32'h0);
        check("fixcancel lo", bus.lo_out, 32'h3);
        $display("cancel fix: hi=0x%h lo=0x%h done=%b", bus.hi_out, bus.lo_out, bus.done);

        // Asynchronous reset mid-division, then MTHI.
        issue(OP_MTHI, 32'hCAFE, 32'h0, 1'b0);
        issue(OP_DIVU, 32'd50, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midreset hi", bus.hi_out, 32'h0);
        check("midreset lo", bus.lo_out, 32'h0);
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        $display("mid-div reset: hi=0x%h lo=0x%h busy=%b", bus.hi_out, bus.lo_out, bus.busy);
        @(negedge clk);
        resetn = 1'b1;
        issue(OP_MTHI, 32'h12345678, 32'h0, 1'b0);
        check("postreset hi", bus.hi_out, 32'h12345678);
        check("postreset lo", bus.lo_out, 32'h0);
        check("postreset done", 32'(bus.done), 32'd1);
        $display("post-reset MTHI: hi=0x%h done=%b", bus.hi_out, bus.done);

        // MACC_EN=0 build: accumulate ops are NOPs.
        @(negedge clk);
        bus_nm.valid = 1'b1; bus_nm.op = OP_MTHI; bus_nm.src_a = 32'h11;
        @(negedge clk);
        bus_nm.op = OP_MTLO; bus_nm.src_a = 32'h22;
        @(negedge clk);
        bus_nm.op = OP_MADD; bus_nm.src_a = 32'h2; bus_nm.src_b = 32'h3;
        @(negedge clk);
        bus_nm.valid = 1'b0; bus_nm.op = OP_NOP;
        check("nomacc madd hi", bus_nm.hi_out, 32'h11);
        check("nomacc madd lo", bus_nm.lo_out, 32'h22);
        check("nomacc madd done", 32'(bus_nm.done), 32'd0);
        $display("nomacc MADD 2x3: hi=0x%h lo=0x%h done=%b", bus_nm.hi_out, bus_nm.lo_out, bus_nm.done);
        bus_nm.valid = 1'b1; bus_nm.op = OP_MULT; bus_nm.src_a = 32'h2; bus_nm.src_b = 32'h3;
        @(negedge clk);
        bus_nm.valid = 1'b0; bus_nm.op = OP_NOP;
        check("nomacc mult hi", bus_nm.hi_out, 32'h0);
        check("nomacc mult lo", bus_nm.lo_out, 32'h6);
        $display("nomacc MULT 2x3: hi=0x%h lo=0x%h", bus_nm.hi_out, bus_nm.lo_out);

        // DATA_W=8 build.
        div8_check("w8_div_ovf",  OP_DIV,  8'h80, 8'hFF, 8'h00, 8'h80);
        div8_check("w8_divu_ff",  OP_DIVU, 8'hFF, 8'h10, 8'h0F, 8'h0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
